// File: rtl/reg_file_sb.sv
// Parametrised register file: two bypassed read ports, ALU and load-return write ports,
// and a per-register busy scoreboard that raises stall on reads of pending load targets.
module reg_file_sb #(
   parameter int unsigned DATA_W   = 16,
   parameter int unsigned REG_N    = 8,
   parameter int unsigned ADDR_W   = $clog2(REG_N),
   parameter int unsigned ZERO_REG = 0,
   localparam int unsigned CNT_W   = $clog2(REG_N + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] raddr1,
   input  logic [ADDR_W-1:0] raddr2,
   input  logic              ren1,
   input  logic              ren2,
   output logic [DATA_W-1:0] rdata1,
   output logic [DATA_W-1:0] rdata2,
   output logic              rbusy1,
   output logic              rbusy2,
   output logic              stall,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              rsv_valid,
   input  logic [ADDR_W-1:0] rsv_addr,
   input  logic              ld_valid,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [DATA_W-1:0] ld_data,
   output logic              rsv_err,
   output logic [CNT_W-1:0]  pending_cnt
);

   logic [DATA_W-1:0] regs [REG_N];
   logic [REG_N-1:0]  busy;
   logic [REG_N-1:0]  busy_nxt;
   logic [REG_N-1:0]  ld_hot;
   logic [REG_N-1:0]  rsv_hot;
   logic              we_eff;
   logic              ld_eff;
   logic              rsv_eff;
   logic              rsv_err_nxt;

   function automatic logic is_zero(input logic [ADDR_W-1:0] a);
      return (ZERO_REG != 0) && (a == '0);
   endfunction

   // Load return has priority over the ALU port, matching the write order below.
   function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] a);
      logic [DATA_W-1:0] d;
      d = regs[a];
      if (we_eff && (waddr == a))   d = wdata;
      if (ld_eff && (ld_addr == a)) d = ld_data;
      if (is_zero(a))               d = '0;
      return d;
   endfunction

   always_comb begin
      we_eff  = we & ~is_zero(waddr);
      ld_eff  = ld_valid & ~is_zero(ld_addr);
      rsv_eff = rsv_valid & ~is_zero(rsv_addr);
      ld_hot  = ld_eff ? (REG_N'(1) << ld_addr) : '0;
      rsv_hot = rsv_eff ? (REG_N'(1) << rsv_addr) : '0;
      // A same-cycle return and reservation leaves the register busy for the new load.
      busy_nxt    = (busy & ~ld_hot) | rsv_hot;
      rsv_err_nxt = rsv_eff & busy[rsv_addr] & ~ld_hot[rsv_addr];
   end

   always_comb begin
      rdata1 = read_port(raddr1);
      rdata2 = read_port(raddr2);
      rbusy1 = busy[raddr1] & ~ld_hot[raddr1] & ~is_zero(raddr1);
      rbusy2 = busy[raddr2] & ~ld_hot[raddr2] & ~is_zero(raddr2);
      stall  = (ren1 & rbusy1) | (ren2 & rbusy2);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         regs        <= '{default: '0};
         busy        <= '0;
         rsv_err     <= 1'b0;
         pending_cnt <= '0;
      end else begin
         if (we_eff) regs[waddr]   <= wdata;
         if (ld_eff) regs[ld_addr] <= ld_data;
         busy        <= busy_nxt;
         rsv_err     <= rsv_err_nxt;
         pending_cnt <= CNT_W'($countones(busy_nxt));
      end
   end

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb: vector table for bypass/scoreboard/reset behaviour,
// plus a hand-written sequence comparing ZERO_REG=0 and ZERO_REG=1 instances on register 0.
module tb_reg_file_sb;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  raddr1, raddr2, waddr, rsv_addr, ld_addr;
   logic        ren1, ren2, we, rsv_valid, ld_valid;
   logic [15:0] wdata, ld_data;

   logic [15:0] rdata1, rdata2, z_rdata1, z_rdata2;
   logic        rbusy1, rbusy2, stall, rsv_err;
   logic        z_rbusy1, z_rbusy2, z_stall, z_rsv_err;
   logic [3:0]  pending_cnt, z_pending_cnt;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   reg_file_sb #(.DATA_W(16), .REG_N(8), .ZERO_REG(0)) u_dut (
      .clk(clk), .rst(rst),
      .raddr1(raddr1), .raddr2(raddr2), .ren1(ren1), .ren2(ren2),
      .rdata1(rdata1), .rdata2(rdata2), .rbusy1(rbusy1), .rbusy2(rbusy2), .stall(stall),
      .we(we), .waddr(waddr), .wdata(wdata),
      .rsv_valid(rsv_valid), .rsv_addr(rsv_addr),
      .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data),
      .rsv_err(rsv_err), .pending_cnt(pending_cnt)
   );

   reg_file_sb #(.DATA_W(16), .REG_N(8), .ZERO_REG(1)) u_dut_z (
      .clk(clk), .rst(rst),
      .raddr1(raddr1), .raddr2(raddr2), .ren1(ren1), .ren2(ren2),
      .rdata1(z_rdata1), .rdata2(z_rdata2), .rbusy1(z_rbusy1), .rbusy2(z_rbusy2), .stall(z_stall),
      .we(we), .waddr(waddr), .wdata(wdata),
      .rsv_valid(rsv_valid), .rsv_addr(rsv_addr),
      .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data),
      .rsv_err(z_rsv_err), .pending_cnt(z_pending_cnt)
   );

   typedef struct {
      int unsigned rst, we, wa, wd, rv, ra, lv, la, ld, r1, e1, r2, e2;
      int unsigned x_rd1, x_rd2, x_rb1, x_rb2, x_st, x_err, x_pend;
   } vec_t;

   vec_t tv[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      rst       = 1'(v.rst);
      we        = 1'(v.we);
      waddr     = 3'(v.wa);
      wdata     = 16'(v.wd);
      rsv_valid = 1'(v.rv);
      rsv_addr  = 3'(v.ra);
      ld_valid  = 1'(v.lv);
      ld_addr   = 3'(v.la);
      ld_data   = 16'(v.ld);
      raddr1    = 3'(v.r1);
      ren1      = 1'(v.e1);
      raddr2    = 3'(v.r2);
      ren2      = 1'(v.e2);
   endtask

   task automatic idle();
      rst = 1'b1; we = 1'b0; rsv_valid = 1'b0; ld_valid = 1'b0;
      waddr = '0; wdata = '0; rsv_addr = '0; ld_addr = '0; ld_data = '0;
      ren1 = 1'b0; ren2 = 1'b0; raddr1 = '0; raddr2 = '0;
   endtask

   initial begin
      // rst, we,wa,wd, rv,ra, lv,la,ld, r1,e1,r2,e2, rd1,rd2,rb1,rb2,stall, err,pend
      tv.push_back('{1,1,3,'h1234, 0,0, 0,0,0,       3,0,3,0, 'h1234,'h1234,0,0,0, 0,0});
      tv.push_back('{1,0,0,0,      0,0, 0,0,0,       3,0,2,0, 'h1234,0,0,0,0,      0,0});
      tv.push_back('{1,1,3,'h5555, 0,0, 1,3,'hBEEF,  3,0,3,0, 'hBEEF,'hBEEF,0,0,0, 0,0});
      tv.push_back('{1,0,0,0,      0,0, 0,0,0,       3,0,1,0, 'hBEEF,0,0,0,0,      0,0});
      tv.push_back('{1,0,0,0,      1,5, 0,0,0,       0,0,5,1, 0,0,0,0,0,           0,1});
      tv.push_back('{1,0,0,0,      0,0, 0,0,0,       5,0,5,1, 0,0,1,1,1,           0,1});
      tv.push_back('{1,1,5,'h7777, 0,0, 0,0,0,       5,1,5,0, 'h7777,'h7777,1,1,1, 0,1});
      tv.push_back('{1,0,0,0,      0,0, 1,5,'h00AA,  5,1,5,1, 'h00AA,'h00AA,0,0,0, 0,0});
      tv.push_back('{1,0,0,0,      0,0, 0,0,0,       5,1,2,0, 'h00AA,0,0,0,0,      0,0});
      tv.push_back('{1,0,0,0,      1,2, 0,0,0,       2,1,0,0, 0,0,0,0,0,           0,1});
      tv.push_back('{1,0,0,0,      1,2, 0,0,0,       2,1,0,0, 0,0,1,0,1,           1,1});
      tv.push_back('{1,0,0,0,      0,0, 0,0,0,       2,1,0,0, 0,0,1,0,1,           0,1});
      tv.push_back('{1,0,0,0,      1,2, 1,2,'h0C0C,  2,1,0,0, 'h0C0C,0,0,0,0,      0,1});
      tv.push_back('{1,0,0,0,      0,0, 0,0,0,       2,1,0,0, 'h0C0C,0,1,0,1,      0,1});
      tv.push_back('{1,0,0,0,      1,6, 1,2,'h1111,  2,1,6,1, 'h1111,0,0,0,0,      0,1});
      tv.push_back('{1,0,0,0,      1,6, 1,1,'h0101,  1,1,6,1, 'h0101,0,0,1,1,      1,1});
      tv.push_back('{1,0,0,0,      0,0, 1,6,'h6666,  1,1,6,1, 'h0101,'h6666,0,0,0, 0,0});
      tv.push_back('{1,0,0,0,      1,1, 0,0,0,       1,0,0,0, 'h0101,0,0,0,0,      0,1});
      tv.push_back('{1,0,0,0,      1,4, 0,0,0,       1,0,0,0, 'h0101,0,1,0,0,      0,2});
      tv.push_back('{1,0,0,0,      1,6, 0,0,0,       1,1,4,1, 'h0101,0,1,1,1,      0,3});
      tv.push_back('{0,1,7,'h9999, 1,3, 0,0,0,       1,1,4,1, 'h0101,0,1,1,1,      0,0});
      tv.push_back('{1,0,0,0,      0,0, 0,0,0,       1,1,4,1, 0,0,0,0,0,           0,0});
      tv.push_back('{1,0,0,0,      0,0, 1,4,'h4444,  7,1,4,1, 0,'h4444,0,0,0,      0,0});
      tv.push_back('{1,0,0,0,      1,4, 0,0,0,       4,1,6,1, 'h4444,0,0,0,0,      0,1});

      // Reset and read every address.
      idle();
      rst = 1'b0;
      @(posedge clk); #1;
      chk("reset pending_cnt", 32'(pending_cnt), 0);
      chk("reset rsv_err", 32'(rsv_err), 0);
      chk("reset z_pending_cnt", 32'(z_pending_cnt), 0);
      rst = 1'b1; ren1 = 1'b1; ren2 = 1'b1;
      for (int a = 0; a < 8; a++) begin
         raddr1 = 3'(a);
         raddr2 = 3'(7 - a);
         #1;
         chk($sformatf("reset rdata1 a%0d", a), 32'(rdata1), 0);
         chk($sformatf("reset rdata2 a%0d", 7 - a), 32'(rdata2), 0);
         chk($sformatf("reset stall a%0d", a), 32'(stall), 0);
      end

      // Table: comb outputs mid-cycle, registered outputs just after the edge.
      @(posedge clk); #1;
      for (int i = 0; i < tv.size(); i++) begin
         drive(tv[i]);
         #3;
         chk($sformatf("v%0d rdata1", i), 32'(rdata1), tv[i].x_rd1);
         chk($sformatf("v%0d rdata2", i), 32'(rdata2), tv[i].x_rd2);
         chk($sformatf("v%0d rbusy1", i), 32'(rbusy1), tv[i].x_rb1);
         chk($sformatf("v%0d rbusy2", i), 32'(rbusy2), tv[i].x_rb2);
         chk($sformatf("v%0d stall", i), 32'(stall), tv[i].x_st);
         @(posedge clk); #1;
         chk($sformatf("v%0d rsv_err", i), 32'(rsv_err), tv[i].x_err);
         chk($sformatf("v%0d pending_cnt", i), 32'(pending_cnt), tv[i].x_pend);
      end

      // Register 0: ordinary on the main instance, hardwired zero on the other.
      idle();
      we = 1'b1; waddr = 3'd0; wdata = 16'hFFFF;
      rsv_valid = 1'b1; rsv_addr = 3'd0;
      raddr1 = 3'd0; ren1 = 1'b1;
      #3;
      chk("z1 z_rdata1", 32'(z_rdata1), 0);
      chk("z1 z_rbusy1", 32'(z_rbusy1), 0);
      chk("z1 rdata1", 32'(rdata1), 32'h0000FFFF);
      @(posedge clk); #1;
      chk("z1 z_pending_cnt", 32'(z_pending_cnt), 1);
      chk("z1 z_rsv_err", 32'(z_rsv_err), 0);
      chk("z1 pending_cnt", 32'(pending_cnt), 2);

      we = 1'b0;
      #3;
      chk("z2 z_rdata1", 32'(z_rdata1), 0);
      chk("z2 z_rbusy1", 32'(z_rbusy1), 0);
      chk("z2 z_stall", 32'(z_stall), 0);
      chk("z2 rbusy1", 32'(rbusy1), 1);
      chk("z2 stall", 32'(stall), 1);
      @(posedge clk); #1;
      chk("z2 z_rsv_err", 32'(z_rsv_err), 0);
      chk("z2 rsv_err", 32'(rsv_err), 1);
      chk("z2 z_pending_cnt", 32'(z_pending_cnt), 1);
      chk("z2 pending_cnt", 32'(pending_cnt), 2);

      rsv_valid = 1'b0;
      ld_valid = 1'b1; ld_addr = 3'd0; ld_data = 16'h0ABC;
      #3;
      chk("z3 z_rdata1", 32'(z_rdata1), 0);
      chk("z3 rdata1", 32'(rdata1), 32'h00000ABC);
      chk("z3 rbusy1", 32'(rbusy1), 0);
      @(posedge clk); #1;
      chk("z3 pending_cnt", 32'(pending_cnt), 1);
      chk("z3 z_pending_cnt", 32'(z_pending_cnt), 1);
      chk("z3 rsv_err", 32'(rsv_err), 0);

      ld_valid = 1'b0;
      #3;
      chk("z4 rdata1", 32'(rdata1), 32'h00000ABC);
      chk("z4 z_rdata1", 32'(z_rdata1), 0);
      chk("z4 z_rsv_err", 32'(z_rsv_err), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
